ysyx_22041461_ifu: RTL and testbench

//   Instruction fetch unit: consumer of the PC stage. Accepts a fetch address (pc/pc_valid/pc_ready),

---
 rtl/ysyx_22041461_pkg.sv | 16 +
 rtl/ysyx_22041461_ifu.sv | 122 ++++++++++++
 tb/tb_ysyx_22041461_ifu.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22041461_pkg.sv
// Shared types and widths for the ysyx_22041461 instruction fetch unit.
// The FSM walks IDLE -> REQ -> WAIT -> RESP with a single fetch outstanding.
package ysyx_22041461_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int INST_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } ifu_state_t;

endpackage

// File: rtl/ysyx_22041461_ifu.sv
// Instruction fetch unit: accepts a pc, performs one 64-bit bus read, picks the
// 32-bit word by pc[2] and hands it to decode; flush kills any in-flight fetch.
module ysyx_22041461_ifu #(
  parameter int ADDR_W = ysyx_22041461_pkg::ADDR_W,
  parameter int DATA_W = ysyx_22041461_pkg::DATA_W,
  parameter int INST_W = ysyx_22041461_pkg::INST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              pc_valid,
  output logic              pc_ready,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rerr,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_misal,
  output logic              inst_afault
);

  import ysyx_22041461_pkg::*;

  ifu_state_t        state_q;
  logic              kill_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              inst_valid_q;
  logic [INST_W-1:0] inst_q;
  logic [ADDR_W-1:0] inst_pc_q;
  logic              inst_misal_q;
  logic              inst_afault_q;
  logic [INST_W-1:0] rdata_word;

  // kill_q only lives in REQ/WAIT, so gating on IDLE already covers it; kept explicit
  assign pc_ready = rst && (state_q == IDLE) && !kill_q && !flush;

  assign rdata_word = inst_pc_q[2] ? mem_rdata[2*INST_W-1:INST_W] : mem_rdata[INST_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      kill_q        <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      inst_valid_q  <= 1'b0;
      inst_q        <= '0;
      inst_pc_q     <= '0;
      inst_misal_q  <= 1'b0;
      inst_afault_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pc_valid && pc_ready) begin
            inst_pc_q <= pc_i;
            if (pc_i[1:0] != 2'b00) begin
              state_q       <= RESP;
              inst_valid_q  <= 1'b1;
              inst_misal_q  <= 1'b1;
              inst_afault_q <= 1'b0;
              inst_q        <= '0;
            end else begin
              state_q    <= REQ;
              mem_req_q  <= 1'b1;
              mem_addr_q <= {pc_i[ADDR_W-1:3], 3'b000};
            end
          end
        end
        // A request already on the bus cannot be retracted; a flush only marks it for discard
        REQ: begin
          if (flush) begin
            kill_q <= 1'b1;
          end
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            if (kill_q || flush) begin
              state_q <= IDLE;
              kill_q  <= 1'b0;
            end else begin
              state_q       <= RESP;
              inst_valid_q  <= 1'b1;
              inst_q        <= rdata_word;
              inst_misal_q  <= 1'b0;
              inst_afault_q <= mem_rerr;
            end
          end else if (flush) begin
            kill_q <= 1'b1;
          end
        end
        RESP: begin
          if (flush || inst_ready) begin
            state_q       <= IDLE;
            inst_valid_q  <= 1'b0;
            inst_misal_q  <= 1'b0;
            inst_afault_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign inst_valid  = inst_valid_q;
  assign inst        = inst_q;
  assign inst_pc     = inst_pc_q;
  assign inst_misal  = inst_misal_q;
  assign inst_afault = inst_afault_q;

endmodule

// File: tb/tb_ysyx_22041461_ifu.sv
// Directed testbench for the ysyx_22041461 IFU: every expected value below is
// hand-computed from the fetch address and the beat the bench returns.
module tb_ysyx_22041461_ifu;

  logic        clk;
  logic        rst;
  logic [63:0] pc_i;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        mem_rerr;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_misal;
  logic        inst_afault;

  int tests;
  int fails;

  ysyx_22041461_ifu dut (
    .clk         (clk),
    .rst         (rst),
    .pc_i        (pc_i),
    .pc_valid    (pc_valid),
    .pc_ready    (pc_ready),
    .flush       (flush),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .mem_rerr    (mem_rerr),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_misal  (inst_misal),
    .inst_afault (inst_afault)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so a broken design can never hang the run
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to 1 ns after the next rising edge, where outputs are stable
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a pc for exactly one edge; the caller makes sure the IFU is ready
  task automatic accept_pc(input logic [63:0] pc);
    pc_i     = pc;
    pc_valid = 1'b1;
    step();
    pc_valid = 1'b0;
  endtask

  // Complete the decode handshake on the current RESP cycle
  task automatic take_inst();
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    tests++;
    if ({mem_req, inst_valid, inst_misal, inst_afault, pc_ready} !== 5'b0) begin
      fails++;
      $display("[TB] FAIL reset_flags: got %b expected 00000", {mem_req, inst_valid, inst_misal, inst_afault, pc_ready});
    end
    tests++;
    if (inst !== 32'h0 || inst_pc !== 64'h0 || mem_addr !== 64'h0) begin
      fails++;
      $display("[TB] FAIL reset_data: inst=%h inst_pc=%h mem_addr=%h expected all 0", inst, inst_pc, mem_addr);
    end
    step();
    step();
    rst = 1'b1;
    #1;
    tests++;
    if (pc_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_release_ready: pc_ready=%b expected 1", pc_ready);
    end
  endtask

  task automatic test_fetch_low_word();
    pc_i     = 64'h8000_0000;
    pc_valid = 1'b1;
    #1;
    tests++;
    if (pc_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL low_accept_ready: pc_ready=%b expected 1", pc_ready);
    end
    step();
    pc_valid = 1'b0;
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h8000_0000) begin
      fails++;
      $display("[TB] FAIL low_req: mem_req=%b mem_addr=%h expected 1 / 80000000", mem_req, mem_addr);
    end
    mem_gnt = 1'b1;
    step();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h1111_2222_0000_0013;
    tests++;
    if (mem_req !== 1'b0 || inst_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL low_wait: mem_req=%b inst_valid=%b expected 0 / 0", mem_req, inst_valid);
    end
    step();
    mem_rvalid = 1'b0;
    tests++;
    if (inst_valid !== 1'b1 || inst !== 32'h0000_0013 || inst_pc !== 64'h8000_0000) begin
      fails++;
      $display("[TB] FAIL low_resp: valid=%b inst=%h pc=%h expected 1 / 00000013 / 80000000", inst_valid, inst, inst_pc);
    end
    tests++;
    if (inst_misal !== 1'b0 || inst_afault !== 1'b0) begin
      fails++;
      $display("[TB] FAIL low_flags: misal=%b afault=%b expected 0 / 0", inst_misal, inst_afault);
    end
    take_inst();
    tests++;
    if (inst_valid !== 1'b0 || pc_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL low_done: inst_valid=%b pc_ready=%b expected 0 / 1", inst_valid, pc_ready);
    end
  endtask

  task automatic test_fetch_high_word();
    accept_pc(64'h8000_0004);
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h8000_0000) begin
      fails++;
      $display("[TB] FAIL high_addr: mem_req=%b mem_addr=%h expected 1 / 80000000", mem_req, mem_addr);
    end
    mem_gnt = 1'b1;
    step();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h1111_2222_0000_0013;
    step();
    mem_rvalid = 1'b0;
    tests++;
    if (inst_valid !== 1'b1 || inst !== 32'h1111_2222 || inst_pc !== 64'h8000_0004) begin
      fails++;
      $display("[TB] FAIL high_resp: valid=%b inst=%h pc=%h expected 1 / 11112222 / 80000004", inst_valid, inst, inst_pc);
    end
    take_inst();
  endtask

  task automatic test_gnt_delay_and_hold();
    accept_pc(64'h8000_0008);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (mem_req !== 1'b1 || mem_addr !== 64'h8000_0008) begin
        fails++;
        $display("[TB] FAIL hold_req[%0d]: mem_req=%b mem_addr=%h expected 1 / 80000008", i, mem_req, mem_addr);
      end
      step();
    end
    mem_gnt = 1'b1;
    step();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hdead_beef_cafe_f00d;
    step();
    mem_rvalid = 1'b0;
    mem_rdata  = 64'h0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (inst_valid !== 1'b1 || inst !== 32'hcafe_f00d || inst_pc !== 64'h8000_0008) begin
        fails++;
        $display("[TB] FAIL hold_inst[%0d]: valid=%b inst=%h pc=%h expected 1 / cafef00d / 80000008", i, inst_valid, inst, inst_pc);
      end
      step();
    end
    take_inst();
    tests++;
    if (inst_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL hold_done: inst_valid=%b expected 0", inst_valid);
    end
  endtask

  task automatic test_misaligned();
    accept_pc(64'h8000_0002);
    tests++;
    if (mem_req !== 1'b0) begin
      fails++;
      $display("[TB] FAIL misal_no_req: mem_req=%b expected 0", mem_req);
    end
    tests++;
    if (inst_valid !== 1'b1 || inst_misal !== 1'b1 || inst !== 32'h0 || inst_pc !== 64'h8000_0002 || inst_afault !== 1'b0) begin
      fails++;
      $display("[TB] FAIL misal_resp: valid=%b misal=%b afault=%b inst=%h pc=%h expected 1 / 1 / 0 / 00000000 / 80000002",
               inst_valid, inst_misal, inst_afault, inst, inst_pc);
    end
    take_inst();
  endtask

  task automatic test_afault();
    accept_pc(64'h8000_0010);
    mem_gnt = 1'b1;
    step();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rerr   = 1'b1;
    mem_rdata  = 64'haaaa_bbbb_cccc_dddd;
    step();
    mem_rvalid = 1'b0;
    mem_rerr   = 1'b0;
    tests++;
    if (inst_valid !== 1'b1 || inst_afault !== 1'b1 || inst_misal !== 1'b0 || inst !== 32'hcccc_dddd) begin
      fails++;
      $display("[TB] FAIL afault_resp: valid=%b afault=%b misal=%b inst=%h expected 1 / 1 / 0 / ccccdddd",
               inst_valid, inst_afault, inst_misal, inst);
    end
    take_inst();
  endtask

  task automatic test_flush_wait();
    accept_pc(64'h8000_0020);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    flush   = 1'b1;
    step();
    flush = 1'b0;
    #1;
    tests++;
    if (pc_ready !== 1'b0 || inst_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL flushw_kill1: pc_ready=%b inst_valid=%b expected 0 / 0", pc_ready, inst_valid);
    end
    step();
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h5555_5555_5555_5555;
    #1;
    tests++;
    if (pc_ready !== 1'b0 || inst_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL flushw_kill2: pc_ready=%b inst_valid=%b expected 0 / 0", pc_ready, inst_valid);
    end
    step();
    mem_rvalid = 1'b0;
    tests++;
    if (inst_valid !== 1'b0 || pc_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL flushw_drop: inst_valid=%b pc_ready=%b expected 0 / 1", inst_valid, pc_ready);
    end
    accept_pc(64'h8000_0100);
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h8000_0100) begin
      fails++;
      $display("[TB] FAIL flushw_next_req: mem_req=%b mem_addr=%h expected 1 / 80000100", mem_req, mem_addr);
    end
    mem_gnt = 1'b1;
    step();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h0000_0000_0010_0093;
    step();
    mem_rvalid = 1'b0;
    tests++;
    if (inst_valid !== 1'b1 || inst !== 32'h0010_0093 || inst_pc !== 64'h8000_0100) begin
      fails++;
      $display("[TB] FAIL flushw_next_resp: valid=%b inst=%h pc=%h expected 1 / 00100093 / 80000100", inst_valid, inst, inst_pc);
    end
    take_inst();
  endtask

  task automatic test_flush_req();
    accept_pc(64'h8000_0040);
    flush = 1'b1;
    step();
    flush = 1'b0;
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h8000_0040 || pc_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL flushr_hold: mem_req=%b mem_addr=%h pc_ready=%b expected 1 / 80000040 / 0", mem_req, mem_addr, pc_ready);
    end
    mem_gnt = 1'b1;
    step();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h7777_7777_7777_7777;
    step();
    mem_rvalid = 1'b0;
    tests++;
    if (inst_valid !== 1'b0 || pc_ready !== 1'b1 || mem_req !== 1'b0) begin
      fails++;
      $display("[TB] FAIL flushr_drop: inst_valid=%b pc_ready=%b mem_req=%b expected 0 / 1 / 0", inst_valid, pc_ready, mem_req);
    end
  endtask

  task automatic test_flush_with_rvalid();
    accept_pc(64'h8000_0048);
    mem_gnt = 1'b1;
    step();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    flush      = 1'b1;
    mem_rdata  = 64'h9999_9999_9999_9999;
    step();
    mem_rvalid = 1'b0;
    flush      = 1'b0;
    #1;
    tests++;
    if (inst_valid !== 1'b0 || pc_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL flushrv_drop: inst_valid=%b pc_ready=%b expected 0 / 1", inst_valid, pc_ready);
    end
  endtask

  task automatic test_flush_resp();
    accept_pc(64'h8000_0080);
    mem_gnt = 1'b1;
    step();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h0000_0000_1234_5678;
    step();
    mem_rvalid = 1'b0;
    tests++;
    if (inst_valid !== 1'b1 || inst !== 32'h1234_5678) begin
      fails++;
      $display("[TB] FAIL flushp_resp: valid=%b inst=%h expected 1 / 12345678", inst_valid, inst);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    tests++;
    if (inst_valid !== 1'b0 || pc_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL flushp_drop: inst_valid=%b pc_ready=%b expected 0 / 1", inst_valid, pc_ready);
    end
  endtask

  task automatic test_reset_mid_fetch();
    accept_pc(64'h8000_0200);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if ({mem_req, inst_valid, inst_misal, inst_afault, pc_ready} !== 5'b0) begin
      fails++;
      $display("[TB] FAIL midrst_flags: got %b expected 00000", {mem_req, inst_valid, inst_misal, inst_afault, pc_ready});
    end
    tests++;
    if (inst !== 32'h0 || inst_pc !== 64'h0 || mem_addr !== 64'h0) begin
      fails++;
      $display("[TB] FAIL midrst_data: inst=%h inst_pc=%h mem_addr=%h expected all 0", inst, inst_pc, mem_addr);
    end
    step();
    rst = 1'b1;
    #1;
    tests++;
    if (pc_ready !== 1'b1 || mem_req !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midrst_release: pc_ready=%b mem_req=%b expected 1 / 0", pc_ready, mem_req);
    end
    accept_pc(64'h8000_0304);
    mem_gnt = 1'b1;
    step();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hfeed_face_0bad_f00d;
    step();
    mem_rvalid = 1'b0;
    tests++;
    if (inst_valid !== 1'b1 || inst !== 32'hfeed_face || inst_pc !== 64'h8000_0304) begin
      fails++;
      $display("[TB] FAIL midrst_refetch: valid=%b inst=%h pc=%h expected 1 / feedface / 80000304", inst_valid, inst, inst_pc);
    end
    take_inst();
  endtask

  // Main sequence: idle every input, then run each scenario back to back
  initial begin
    tests      = 0;
    fails      = 0;
    rst        = 1'b0;
    pc_i       = 64'h0;
    pc_valid   = 1'b0;
    flush      = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 64'h0;
    mem_rerr   = 1'b0;
    inst_ready = 1'b0;

    test_reset();
    test_fetch_low_word();
    test_fetch_high_word();
    test_gnt_delay_and_hold();
    test_misaligned();
    test_afault();
    test_flush_wait();
    test_flush_req();
    test_flush_with_rvalid();
    test_flush_resp();
    test_reset_mid_fetch();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
